instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 217 +++++++++++++++++++++
 tb/tb_instruction_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// UART boot loader: receives a 16-bit little-endian word count followed by
// that many 32-bit little-endian instruction words over an 8N1 serial line,
// writes them into instruction memory, and holds the core in reset meanwhile.
module instruction_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IMEM_AW      = 8,
  parameter int TIMEOUT      = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  input  logic               load_en,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IMEM_AW:0]   words_loaded
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  // Largest word count that fits without the address wrapping.
  localparam logic [16:0]   N_MAX     = 17'(2 ** IMEM_AW);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, DONE, ERROR} state_t;

  // ---------------------------------------------------------------- receiver
  rx_state_t     rx_state_reg, rx_state_next;
  logic          rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_fall, half_tick, full_tick;
  logic          rx_start_ok, rx_sample, rx_byte_done, rx_active;
  logic          byte_ok, frame_err;

  assign rx_fall   = rx_prev_reg & ~rx_sync2_reg;
  assign half_tick = (baud_cnt_reg == HALF_LAST);
  assign full_tick = (baud_cnt_reg == FULL_LAST);
  assign byte_ok   = rx_byte_done &  rx_sync2_reg;
  assign frame_err = rx_byte_done & ~rx_sync2_reg;

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_reg <= RX_IDLE;
    else        rx_state_reg <= rx_state_next;
  end

  // Receiver next state: a start edge is only believed if still low mid-bit.
  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      RX_START: if (half_tick) rx_state_next = rx_sync2_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_cnt_reg == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (full_tick) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // Receiver strobes, decoded from the current state and the bit timer.
  always_comb begin
    rx_start_ok  = (rx_state_reg == RX_START) && half_tick && !rx_sync2_reg;
    rx_sample    = (rx_state_reg == RX_DATA) && full_tick;
    rx_byte_done = (rx_state_reg == RX_STOP) && full_tick;
    rx_active    = (rx_state_reg != RX_IDLE);
  end

  // Line synchronizer, bit timer, bit counter and LSB-first shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_prev_reg  <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_sync1_reg <= uart_rx;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
      if (rx_state_reg == RX_IDLE || rx_start_ok || full_tick) baud_cnt_reg <= '0;
      else                                                     baud_cnt_reg <= baud_cnt_reg + 1'b1;
      if (rx_start_ok)    bit_cnt_reg <= '0;
      else if (rx_sample) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (rx_sample) rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
    end
  end

  // ------------------------------------------------------------ load control
  state_t           state_reg, state_next;
  logic [7:0]       n_lo_reg;
  logic [IMEM_AW:0] n_reg;
  logic [1:0]       byte_cnt_reg;
  logic [31:0]      word_reg;
  logic [TW-1:0]    to_cnt_reg;
  logic             imem_we_reg, core_rst_n_reg, done_reg, error_reg;
  logic [IMEM_AW-1:0] imem_addr_reg;
  logic [31:0]      imem_wdata_reg;
  logic [IMEM_AW:0] words_loaded_reg, wl_inc;
  logic [15:0]      n_full;
  logic             loading, timeout_hit, abort;
  logic             load_start, enter_done, enter_error, accept_data;

  assign n_full      = {rx_shift_reg, n_lo_reg};
  assign wl_inc      = words_loaded_reg + 1'b1;
  assign loading     = (state_reg == HDR_LO) || (state_reg == HDR_HI) || (state_reg == DATA);
  assign timeout_hit = (to_cnt_reg == TIMEOUT_V);
  assign abort       = !load_en || frame_err || timeout_hit;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Control next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (load_en && rx_start_ok) state_next = HDR_LO;
      HDR_LO: begin
        if (abort)        state_next = ERROR;
        else if (byte_ok) state_next = HDR_HI;
      end
      HDR_HI: begin
        if (abort) state_next = ERROR;
        else if (byte_ok) begin
          if (n_full == 16'd0)           state_next = DONE;
          else if ({1'b0, n_full} > N_MAX) state_next = ERROR;
          else                           state_next = DATA;
        end
      end
      DATA: begin
        if (abort)                                  state_next = ERROR;
        else if (imem_we_reg && wl_inc == n_reg)    state_next = DONE;
      end
      DONE:   state_next = IDLE;
      ERROR:  if (!load_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs and transition strobes.
  always_comb begin
    busy        = (state_reg != IDLE);
    load_start  = (state_reg == IDLE) && (state_next == HDR_LO);
    enter_done  = (state_next == DONE) && (state_reg != DONE);
    enter_error = (state_next == ERROR) && (state_reg != ERROR);
    accept_data = (state_reg == DATA) && (state_next == DATA) && byte_ok;
  end

  // Inter-byte watchdog: runs only while loading and the line is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      to_cnt_reg <= '0;
    else if (!loading || rx_active || load_start)    to_cnt_reg <= '0;
    else if (!timeout_hit)                           to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  // Header capture, word assembly, memory write port and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n_reg   <= 1'b0;
      imem_we_reg      <= 1'b0;
      imem_addr_reg    <= '0;
      imem_wdata_reg   <= '0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      words_loaded_reg <= '0;
      n_lo_reg         <= '0;
      n_reg            <= '0;
      byte_cnt_reg     <= '0;
      word_reg         <= '0;
    end else begin
      // Core runs only while idle; goes low together with the HDR_LO entry.
      core_rst_n_reg <= (state_next == IDLE);
      imem_we_reg    <= 1'b0;
      if (load_start) begin
        done_reg         <= 1'b0;
        error_reg        <= 1'b0;
        words_loaded_reg <= '0;
      end
      if (enter_done)  done_reg  <= 1'b1;
      if (enter_error) error_reg <= 1'b1;
      if (state_reg == HDR_LO && byte_ok) n_lo_reg <= rx_shift_reg;
      if (state_reg == HDR_HI && byte_ok) n_reg    <= n_full[IMEM_AW:0];
      if (accept_data) begin
        word_reg     <= {rx_shift_reg, word_reg[31:8]};
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        if (byte_cnt_reg == 2'd3) begin
          imem_we_reg    <= 1'b1;
          imem_addr_reg  <= words_loaded_reg[IMEM_AW-1:0];
          imem_wdata_reg <= {rx_shift_reg, word_reg[31:8]};
        end
      end
      if (state_reg == DATA && imem_we_reg) words_loaded_reg <= wl_inc;
      // A partial word never survives an abort or a new load.
      if (load_start || enter_error) byte_cnt_reg <= '0;
    end
  end

  assign imem_we      = imem_we_reg;
  assign imem_addr    = imem_addr_reg;
  assign imem_wdata   = imem_wdata_reg;
  assign core_rst_n   = core_rst_n_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed boot-loader scenarios plus random
// loads checked against a byte-stream model of the expected memory writes.
module tb_instruction_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int TO  = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          load_en = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n, busy, done, error;
  logic [AW:0]   words_loaded;

  int tests_run = 0;
  int tests_failed = 0;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [7:0]    pay[$];

  instruction_loader #(.CLKS_PER_BIT(CPB), .IMEM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .load_en(load_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      $display("[TB] write addr=%0d data=0x%08h", imem_addr, imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(CPB);
    end
    uart_rx = stop_bit;
    cycles(CPB);
    uart_rx = 1'b1;
    cycles(4);
  endtask

  task automatic rand_payload(input int n);
    pay.delete();
    for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_writes();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic recover();
    load_en = 1'b0;
    cycles(3);
    load_en = 1'b1;
    cycles(2);
  endtask

  // Full well-formed load of n words from pay[]; model: word i is bytes
  // 4i..4i+3 little-endian, written at address i, then done with count n.
  task automatic load_and_check(input string tag, input int n);
    logic [31:0] exp_w[$];
    logic [15:0] nh;
    nh = 16'(n);
    clear_writes();
    for (int i = 0; i < n; i++)
      exp_w.push_back({pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]});
    send_byte(nh[7:0], 1'b1);
    send_byte(nh[15:8], 1'b1);
    foreach (pay[i]) send_byte(pay[i], 1'b1);
    cycles(8);
    $display("[TB] %s: N=%0d writes=%0d done=%0b error=%0b", tag, n, got_data.size(), done, error);
    check({tag, "_nwrites"}, 64'(got_data.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_data.size(); i++) begin
      check({tag, "_addr"}, 64'(got_addr[i]), 64'(i));
      check({tag, "_data"}, 64'(got_data[i]), 64'(exp_w[i]));
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_words"}, 64'(words_loaded), 64'(n));
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic saw_busy;
    int   n;

    // Reset values, then core released on the first clock after reset.
    cycles(3);
    check("rst_we", 64'(imem_we), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_wdata", 64'(imem_wdata), 64'(0));
    check("rst_core_rst_n", 64'(core_rst_n), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flags", 64'({done, error}), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    rst_n = 1'b1;
    cycles(1);
    check("rel_core_rst_n", 64'(core_rst_n), 64'(1));
    $display("[TB] reset release: core_rst_n=%0b", core_rst_n);

    // Two-word reference program.
    load_en = 1'b1;
    cycles(2);
    pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    load_and_check("prog2", 2);
    if (got_data.size() == 2) begin
      check("prog2_w0", 64'(got_data[0]), 64'h00A00513);
      check("prog2_w1", 64'(got_data[1]), 64'h00100593);
    end else begin
      check("prog2_count", 64'(got_data.size()), 64'(2));
    end

    // Empty program.
    pay.delete();
    load_and_check("hdr0", 0);

    // Oversized header: one more word than the memory holds.
    clear_writes();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    cycles(20);
    $display("[TB] n17: error=%0b core_rst_n=%0b", error, core_rst_n);
    check("n17_error", 64'(error), 64'(1));
    check("n17_done", 64'(done), 64'(0));
    check("n17_core_rst_n_held", 64'(core_rst_n), 64'(0));
    check("n17_busy", 64'(busy), 64'(1));
    check("n17_nwrites", 64'(got_data.size()), 64'(0));
    load_en = 1'b0;
    cycles(3);
    check("n17_release_core", 64'(core_rst_n), 64'(1));
    check("n17_release_busy", 64'(busy), 64'(0));
    check("n17_error_sticky", 64'(error), 64'(1));
    load_en = 1'b1;
    cycles(2);

    // Inter-byte timeout after half a word.
    clear_writes();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    cycles(1800);
    check("to_not_yet", 64'(error), 64'(0));
    cycles(300);
    $display("[TB] timeout: error=%0b writes=%0d", error, got_data.size());
    check("to_error", 64'(error), 64'(1));
    check("to_core_rst_n", 64'(core_rst_n), 64'(0));
    check("to_nwrites", 64'(got_data.size()), 64'(0));
    recover();

    // Framing error on the third byte, then a clean load clears error.
    clear_writes();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b0);
    cycles(20);
    $display("[TB] framing: error=%0b writes=%0d", error, got_data.size());
    check("fe_error", 64'(error), 64'(1));
    check("fe_nwrites", 64'(got_data.size()), 64'(0));
    recover();
    rand_payload(1);
    load_and_check("after_fe", 1);

    // load_en dropped mid-load.
    clear_writes();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAB, 1'b1);
    load_en = 1'b0;
    cycles(4);
    $display("[TB] load_en drop: error=%0b busy=%0b", error, busy);
    check("drop_error", 64'(error), 64'(1));
    check("drop_busy", 64'(busy), 64'(0));
    check("drop_nwrites", 64'(got_data.size()), 64'(0));
    load_en = 1'b1;
    cycles(2);
    rand_payload(2);
    load_and_check("after_drop", 2);

    // Short low glitch while idle must not start a load.
    saw_busy = 1'b0;
    uart_rx = 1'b0;
    cycles(4);
    uart_rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    $display("[TB] glitch: saw_busy=%0b done=%0b", saw_busy, done);
    check("glitch_busy", 64'(saw_busy), 64'(0));
    check("glitch_done_kept", 64'(done), 64'(1));

    // Traffic with load_en low is ignored.
    clear_writes();
    load_en = 1'b0;
    cycles(2);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    $display("[TB] ignored traffic: busy=%0b done=%0b error=%0b", busy, done, error);
    check("ign_busy", 64'(busy), 64'(0));
    check("ign_done_kept", 64'(done), 64'(1));
    check("ign_error", 64'(error), 64'(0));
    check("ign_nwrites", 64'(got_data.size()), 64'(0));
    load_en = 1'b1;
    cycles(2);

    // Random programs, then a full-memory program.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 8);
      rand_payload(n);
      load_and_check($sformatf("rand%0d", r), n);
    end
    rand_payload(16);
    load_and_check("full16", 16);

    // Asynchronous reset in the middle of the data phase.
    clear_writes();
    rand_payload(3);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
    check("mid_words_before", 64'(words_loaded), 64'(1));
    @(negedge clk);
    uart_rx = 1'b0;
    cycles(40);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-data: busy=%0b core_rst_n=%0b words=%0d", busy, core_rst_n, words_loaded);
    check("mid_rst_we", 64'(imem_we), 64'(0));
    check("mid_rst_addr", 64'(imem_addr), 64'(0));
    check("mid_rst_wdata", 64'(imem_wdata), 64'(0));
    check("mid_rst_core_rst_n", 64'(core_rst_n), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_flags", 64'({done, error}), 64'(0));
    check("mid_rst_words", 64'(words_loaded), 64'(0));
    uart_rx = 1'b1;
    cycles(20);
    check("mid_rst_nwrites", 64'(got_data.size()), 64'(1));
    rst_n = 1'b1;
    cycles(1);
    check("mid_rel_core_rst_n", 64'(core_rst_n), 64'(1));
    cycles(CPB * 12);
    check("mid_rel_busy", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
